// File: rtl/nms_stream_3x3.sv
// Streaming 3x3 non-maximum suppression over raster-order {pixel, score}.
// Two line buffers feed a window; the centre trails the input by IMG_W+1 pixels.
module nms_stream_3x3 #(
   parameter int unsigned IMG_W    = 160,
   parameter int unsigned IMG_H    = 120,
   parameter int unsigned PXL_W    = 8,
   parameter int unsigned SCORE_W  = 12,
   parameter int unsigned TIE_MODE = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic                      in_sof,
   input  logic [PXL_W-1:0]          in_pixel,
   input  logic [SCORE_W-1:0]        in_score,
   input  logic [SCORE_W-1:0]        min_score,
   output logic                      out_valid,
   output logic                      out_sof,
   output logic [$clog2(IMG_W)-1:0]  out_x,
   output logic [$clog2(IMG_H)-1:0]  out_y,
   output logic [PXL_W-1:0]          out_pixel,
   output logic [SCORE_W-1:0]        out_score,
   output logic                      out_is_corner
);

   localparam int unsigned XW = $clog2(IMG_W);
   localparam int unsigned YW = $clog2(IMG_H);

   typedef struct packed {
      logic [PXL_W-1:0]   pixel;
      logic [SCORE_W-1:0] score;
   } tap_t;

   tap_t               lineMid [IMG_W];
   logic [SCORE_W-1:0] lineTop [IMG_W];

   logic [XW-1:0]      xPos, curX, cenX;
   logic [YW-1:0]      yPos, curY, cenY;
   logic [SCORE_W-1:0] topL, topC, midL, botL, botC, topR;
   tap_t               midC, inTap, aboveTap;
   logic               emit, beatAll, atBorder, isCorner;

   // Incoming pixel closes the right-hand window column; centre is the held mid tap.
   always_comb begin
      curX     = in_sof ? '0 : xPos;
      curY     = in_sof ? '0 : yPos;
      inTap    = '{pixel: in_pixel, score: in_score};
      aboveTap = lineMid[curX];
      topR     = lineTop[curX];
      if (curX != '0) begin
         cenX = curX - XW'(1);
         cenY = curY - YW'(1);
      end else begin
         cenX = XW'(IMG_W - 1);
         cenY = curY - YW'(2);
      end
      emit = (curY > YW'(1)) || ((curY == YW'(1)) && (curX != '0));
      beatAll = (midC.score > topL) && (midC.score > topC) &&
                (midC.score > topR) && (midC.score > midL);
      if (TIE_MODE != 0) begin
         beatAll = beatAll && (midC.score >= aboveTap.score) && (midC.score >= botL) &&
                   (midC.score >= botC) && (midC.score >= in_score);
      end else begin
         beatAll = beatAll && (midC.score > aboveTap.score) && (midC.score > botL) &&
                   (midC.score > botC) && (midC.score > in_score);
      end
      atBorder = (cenX == '0) || (cenX == XW'(IMG_W - 1)) || (cenY == '0);
      isCorner = !atBorder && beatAll && (midC.score >= min_score) && (midC.score != '0);
   end

   // Line buffers are never cleared; stale entries only reach border centres.
   always_ff @(posedge clk) begin
      if (in_valid) begin
         lineMid[curX] <= inTap;
         lineTop[curX] <= aboveTap.score;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xPos          <= '0;
         yPos          <= '0;
         topL          <= '0;
         topC          <= '0;
         midL          <= '0;
         midC          <= '0;
         botL          <= '0;
         botC          <= '0;
         out_valid     <= 1'b0;
         out_sof       <= 1'b0;
         out_x         <= '0;
         out_y         <= '0;
         out_pixel     <= '0;
         out_score     <= '0;
         out_is_corner <= 1'b0;
      end else begin
         out_valid     <= in_valid && emit;
         out_sof       <= in_valid && emit && (cenX == '0) && (cenY == '0);
         out_is_corner <= in_valid && emit && isCorner;
         if (in_valid) begin
            topL <= topC;
            topC <= topR;
            midL <= midC.score;
            midC <= aboveTap;
            botL <= botC;
            botC <= in_score;
            if (curX == XW'(IMG_W - 1)) begin
               xPos <= '0;
               yPos <= (curY == YW'(IMG_H - 1)) ? '0 : curY + YW'(1);
            end else begin
               xPos <= curX + XW'(1);
               yPos <= curY;
            end
            if (emit) begin
               out_x     <= cenX;
               out_y     <= cenY;
               out_pixel <= midC.pixel;
               out_score <= midC.score;
            end
         end
      end
   end

endmodule

// File: tb/tb_nms_stream_3x3.sv
// Bench for nms_stream_3x3: two instances (TIE_MODE 0/1) checked each cycle
// against a frame-array model, plus directed literal expectations.
module tb_nms_stream_3x3;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int N  = W * H;
   localparam int PW = 8;
   localparam int SW = 12;
   localparam int XW = 3;
   localparam int YW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_sof = 1'b0;
   logic [PW-1:0] in_pixel = '0;
   logic [SW-1:0] in_score = '0;
   logic [SW-1:0] min_score = '0;

   logic          oValid [2];
   logic          oSof   [2];
   logic [XW-1:0] oX     [2];
   logic [YW-1:0] oY     [2];
   logic [PW-1:0] oPix   [2];
   logic [SW-1:0] oScore [2];
   logic          oCor   [2];

   nms_stream_3x3 #(.IMG_W(W), .IMG_H(H), .PXL_W(PW), .SCORE_W(SW), .TIE_MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
      .in_pixel(in_pixel), .in_score(in_score), .min_score(min_score),
      .out_valid(oValid[0]), .out_sof(oSof[0]), .out_x(oX[0]), .out_y(oY[0]),
      .out_pixel(oPix[0]), .out_score(oScore[0]), .out_is_corner(oCor[0]));

   nms_stream_3x3 #(.IMG_W(W), .IMG_H(H), .PXL_W(PW), .SCORE_W(SW), .TIE_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
      .in_pixel(in_pixel), .in_score(in_score), .min_score(min_score),
      .out_valid(oValid[1]), .out_sof(oSof[1]), .out_x(oX[1]), .out_y(oY[1]),
      .out_pixel(oPix[1]), .out_score(oScore[1]), .out_is_corner(oCor[1]));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // Reference model: the current frame stored by raster index
   int mScore [N];
   int mPix   [N];
   int mk, mLastK;
   int eValid [2], eSof [2], eCor [2], eX [2], eY [2], ePix [2], eScore [2];

   function automatic int modelCorner(input int c, input int mode, input int minS);
      int cx, cy, cs, n;
      bit earlier;
      cx = c % W;
      cy = c / W;
      cs = mScore[c];
      if (cx == 0 || cx == W - 1 || cy == 0) return 0;
      if (cs < minS || cs == 0) return 0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            if (dy == 0 && dx == 0) continue;
            n = mScore[c + dy * W + dx];
            earlier = (dy < 0) || (dy == 0 && dx < 0);
            if (mode == 1 && !earlier) begin
               if (cs < n) return 0;
            end else if (cs <= n) begin
               return 0;
            end
         end
      end
      return 1;
   endfunction

   initial begin
      int k, c;
      mk = 0;
      mLastK = 0;
      for (int m = 0; m < 2; m++) begin
         eValid[m] = 0; eSof[m] = 0; eCor[m] = 0;
         eX[m] = 0; eY[m] = 0; ePix[m] = 0; eScore[m] = 0;
      end
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            mk = 0;
            for (int m = 0; m < 2; m++) begin
               eValid[m] = 0; eSof[m] = 0; eCor[m] = 0;
               eX[m] = 0; eY[m] = 0; ePix[m] = 0; eScore[m] = 0;
            end
         end else begin
            for (int m = 0; m < 2; m++) begin
               eValid[m] = 0; eSof[m] = 0; eCor[m] = 0;
            end
            if (in_valid) begin
               k = in_sof ? 0 : mk;
               mScore[k] = int'(in_score);
               mPix[k]   = int'(in_pixel);
               mk        = (k + 1) % N;
               mLastK    = k;
               if (k >= W + 1) begin
                  c = k - (W + 1);
                  for (int m = 0; m < 2; m++) begin
                     eValid[m] = 1;
                     eSof[m]   = (c == 0) ? 1 : 0;
                     eX[m]     = c % W;
                     eY[m]     = c / W;
                     ePix[m]   = mPix[c];
                     eScore[m] = mScore[c];
                     eCor[m]   = modelCorner(c, m, int'(min_score));
                  end
               end
            end
         end
      end
   end

   typedef struct packed {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
      logic [PW-1:0] pix;
      logic [SW-1:0] sc;
      logic          cor;
      logic          sof;
   } ev_t;

   ev_t seq[$];
   ev_t seqA[$];
   int  validCount0 = 0;
   int  corners0 = 0, corners1 = 0;
   int  lastCx0 = -1, lastCy0 = -1, lastPix0 = -1, cornerK0 = -1;
   int  lastCx1 = -1, lastCy1 = -1;

   // Per-cycle compare of both instances against the model
   initial begin
      forever begin
         @(posedge clk);
         #1;
         for (int m = 0; m < 2; m++) begin
            chk($sformatf("d%0d_valid", m), oValid[m], eValid[m]);
            chk($sformatf("d%0d_sof", m), oSof[m], eSof[m]);
            chk($sformatf("d%0d_corner", m), oCor[m], eCor[m]);
            chk($sformatf("d%0d_x", m), oX[m], eX[m]);
            chk($sformatf("d%0d_y", m), oY[m], eY[m]);
            chk($sformatf("d%0d_pixel", m), oPix[m], ePix[m]);
            chk($sformatf("d%0d_score", m), oScore[m], eScore[m]);
         end
         if (oValid[0] === 1'b1) begin
            validCount0++;
            seq.push_back('{x: oX[0], y: oY[0], pix: oPix[0], sc: oScore[0],
                            cor: oCor[0], sof: oSof[0]});
            if (oCor[0] === 1'b1) begin
               corners0++;
               lastCx0  = int'(oX[0]);
               lastCy0  = int'(oY[0]);
               lastPix0 = int'(oPix[0]);
               cornerK0 = mLastK;
            end
         end
         if (oValid[1] === 1'b1 && oCor[1] === 1'b1) begin
            corners1++;
            lastCx1 = int'(oX[1]);
            lastCy1 = int'(oY[1]);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   int imgScore [N];
   int imgPix   [N];

   task automatic drive(input bit sof, input int p, input int s, input int mn);
      @(negedge clk);
      in_valid  = 1'b1;
      in_sof    = sof;
      in_pixel  = PW'(p);
      in_score  = SW'(s);
      min_score = SW'(mn);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid  = 1'b0;
         in_sof    = 1'($urandom);
         in_pixel  = PW'($urandom);
         in_score  = SW'($urandom);
         min_score = SW'($urandom);
      end
   endtask

   task automatic setBase(input int s);
      for (int k = 0; k < N; k++) begin
         imgScore[k] = s;
         imgPix[k]   = (k * 7 + 3) % 256;
      end
   endtask

   task automatic feedFrame(input int gapMax, input int mn);
      for (int k = 0; k < N; k++) begin
         if (gapMax > 0) idle(int'($urandom_range(0, gapMax)));
         drive(k == 0, imgPix[k], imgScore[k], mn);
      end
      idle(4);
   endtask

   task automatic clearTally();
      corners0 = 0; corners1 = 0;
      lastCx0 = -1; lastCy0 = -1; lastPix0 = -1; cornerK0 = -1;
      lastCx1 = -1; lastCy1 = -1;
      seq.delete();
   endtask

   task automatic checkOutputsZero(input string nm);
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("%s_d%0d_valid", nm, m), oValid[m], 0);
         chk($sformatf("%s_d%0d_sof", nm, m), oSof[m], 0);
         chk($sformatf("%s_d%0d_x", nm, m), oX[m], 0);
         chk($sformatf("%s_d%0d_y", nm, m), oY[m], 0);
         chk($sformatf("%s_d%0d_pixel", nm, m), oPix[m], 0);
         chk($sformatf("%s_d%0d_score", nm, m), oScore[m], 0);
         chk($sformatf("%s_d%0d_corner", nm, m), oCor[m], 0);
      end
   endtask

   initial begin
      int v0;
      bit sof;
      idle(3);
      @(posedge clk);
      #2;
      checkOutputsZero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      // Reset mid-stream, then restart without sof
      setBase(10);
      for (int k = 0; k < 20; k++) drive(k == 0, k, int'($urandom_range(0, 20)), 0);
      @(posedge clk);
      #2;
      chk("t1_valid_before_reset", oValid[0], 1);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      checkOutputsZero("t1_async");
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      v0 = validCount0;
      for (int k = 0; k < 9; k++) drive(1'b0, k, int'($urandom_range(0, 20)), 0);
      @(posedge clk);
      #2;
      chk("t1_no_valid_9", validCount0 - v0, 0);
      drive(1'b0, 9, 5, 0);
      @(posedge clk);
      #2;
      chk("t1_valid_10", oValid[0], 1);
      chk("t1_sof_10", oSof[0], 1);
      chk("t1_x_10", oX[0], 0);
      chk("t1_y_10", oY[0], 0);
      idle(4);

      // Single peak
      setBase(10);
      imgScore[19] = 100;
      imgPix[19]   = 8'hA5;
      clearTally();
      feedFrame(0, 0);
      chk("t2_corners0", corners0, 1);
      chk("t2_corners1", corners1, 1);
      chk("t2_x", lastCx0, 3);
      chk("t2_y", lastCy0, 2);
      chk("t2_pixel", lastPix0, 8'hA5);
      chk("t2_accept_index", cornerK0, 28);
      chk("t2_emitted", seq.size(), N - (W + 1));
      seqA = seq;

      // Same frame with idle gaps
      clearTally();
      feedFrame(3, 0);
      chk("t5_len", seq.size(), seqA.size());
      for (int i = 0; i < seq.size() && i < seqA.size(); i++)
         chk($sformatf("t5_ev%0d", i), seq[i], seqA[i]);

      // Tied pair
      setBase(10);
      imgScore[19] = 50;
      imgScore[20] = 50;
      clearTally();
      feedFrame(0, 0);
      chk("t3_corners0", corners0, 0);
      chk("t3_corners1", corners1, 1);
      chk("t3_x1", lastCx1, 3);
      chk("t3_y1", lastCy1, 2);

      // Border peaks
      setBase(10);
      imgScore[2 * W + 0] = 200;
      imgScore[3 * W + 7] = 200;
      clearTally();
      feedFrame(0, 0);
      chk("t4_border0", corners0, 0);
      chk("t4_border1", corners1, 0);

      // Threshold boundary
      setBase(10);
      imgScore[19] = 100;
      clearTally();
      feedFrame(0, 101);
      chk("t4_min101_0", corners0, 0);
      chk("t4_min101_1", corners1, 0);
      clearTally();
      feedFrame(0, 100);
      chk("t4_min100_0", corners0, 1);
      chk("t4_min100_1", corners1, 1);

      // Sof reasserted on the 21st pixel
      setBase(10);
      for (int k = 0; k < 20; k++) drive(k == 0, imgPix[k], imgScore[k], 0);
      drive(1'b1, 1, 10, 0);
      v0 = validCount0;
      for (int k = 1; k < 9; k++) drive(1'b0, k, 10, 0);
      @(posedge clk);
      #2;
      chk("t6_no_valid_9", validCount0 - v0, 0);
      drive(1'b0, 9, 10, 0);
      @(posedge clk);
      #2;
      chk("t6_valid_10", oValid[0], 1);
      chk("t6_sof_10", oSof[0], 1);
      chk("t6_x_10", oX[0], 0);
      chk("t6_y_10", oY[0], 0);
      idle(4);

      // Random streams: ties, thresholds, gaps, stray sof, wrap without sof
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 130; i++) begin
            idle(int'($urandom_range(0, 2)));
            sof = (i == 0) || ($urandom_range(0, 59) == 0);
            drive(sof, int'($urandom_range(0, 255)),
                  (r[0]) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)));
         end
         idle(3);
      end

      idle(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
